btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pkg.sv | 11 +
 rtl/sync_ff.sv | 19 +
 rtl/btn_pulse_gen.sv | 57 +++++
 tb/tb_btn_pulse_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default parameters for the button pulse generator
package btn_pkg;
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    WAIT_HIGH = 4'b0010,
    PRESSED   = 4'b0100,
    WAIT_LOW  = 4'b1000
  } btn_state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 16;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop chain bringing an asynchronous level into the clk_i domain
module sync_ff
  import btn_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] q;
  // shift the raw level through the chain; the last stage is the safe sample
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q <= '0;
    else q <= {q[STAGES-2:0], d_i};
  end
  assign q_o = q[STAGES-1];
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounces a push button and emits one pulse per accepted press
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic p_o,
  output logic level_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  btn_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic s;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (btn_i),
    .q_o   (s)
  );
  // qualify each level change over DEB_CYCLES stable samples; a glitch returns to the old level
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    case (state)
      IDLE:      state_nxt = s ? WAIT_HIGH : IDLE;
      WAIT_HIGH: begin
        state_nxt = !s ? IDLE : (cnt == CNT_MAX ? PRESSED : WAIT_HIGH);
        cnt_nxt   = (s && cnt != CNT_MAX) ? cnt + 1'b1 : '0;
      end
      PRESSED:   state_nxt = s ? PRESSED : WAIT_LOW;
      WAIT_LOW:  begin
        state_nxt = s ? PRESSED : (cnt == CNT_MAX ? IDLE : WAIT_LOW);
        cnt_nxt   = (!s && cnt != CNT_MAX) ? cnt + 1'b1 : '0;
      end
      default:   state_nxt = IDLE;
    endcase
  end
  // state register plus registered outputs aligned with the state they describe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      p_o     <= 1'b0;
      level_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      p_o     <= (state == WAIT_HIGH) && (state_nxt == PRESSED);
      level_o <= (state_nxt == PRESSED) || (state_nxt == WAIT_LOW);
    end
  end
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed scenarios with a pulse-time scoreboard for two debounce configurations
module tb_btn_pulse_gen;
  localparam int N  = 2;
  localparam int D  = 4;
  localparam int DB = 1;
  logic clk = 0, rst_n = 1, btn_a = 0, btn_b = 0;
  logic p_a, lvl_a, p_b, lvl_b;
  int cyc = 0, checks = 0, errors = 0, pulses_a = 0, pulses_b = 0, exp_a = 0;
  int qa[$], qb[$];

  btn_pulse_gen #(.SYNC_STAGES(N), .DEB_CYCLES(D)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_a), .p_o(p_a), .level_o(lvl_a));
  btn_pulse_gen #(.SYNC_STAGES(N), .DEB_CYCLES(DB)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_b), .p_o(p_b), .level_o(lvl_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_a();
    btn_a = 1;
    qa.push_back(cyc + 1 + N + D);
    exp_a++;
  endtask

  // every observed pulse must match the next scheduled pulse cycle
  always @(negedge clk) begin
    if (p_a === 1'b1) begin
      pulses_a++;
      if (qa.size() == 0) chk("p_a_unexpected", cyc, 32'hFFFF_FFFF);
      else chk("p_a_time", cyc, qa.pop_front());
    end
    if (p_b === 1'b1) begin
      pulses_b++;
      if (qb.size() == 0) chk("p_b_unexpected", cyc, 32'hFFFF_FFFF);
      else chk("p_b_time", cyc, qb.pop_front());
    end
  end

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_p_a", p_a, 0);
    chk("rst_lvl_a", lvl_a, 0);
    chk("rst_p_b", p_b, 0);
    chk("rst_lvl_b", lvl_b, 0);
    wait_n(2);
    rst_n = 1;
    wait_n(3);
    press_a();
    wait_n(N + D);
    chk("lvl_before_press", lvl_a, 0);
    wait_n(1);
    chk("lvl_at_press", lvl_a, 1);
    wait_n(10);
    chk("lvl_hold", lvl_a, 1);
    chk("single_pulse_hold", pulses_a, exp_a);
    btn_a = 0;
    wait_n(N + D);
    chk("lvl_before_release", lvl_a, 1);
    wait_n(1);
    chk("lvl_after_release", lvl_a, 0);
    wait_n(5);
    repeat (5) begin
      btn_a = 1;
      wait_n(3);
      btn_a = 0;
      wait_n(1);
      chk("lvl_short_bounce", lvl_a, 0);
    end
    wait_n(10);
    chk("no_pulse_bounce", pulses_a, exp_a);
    press_a();
    wait_n(12);
    chk("lvl_pressed2", lvl_a, 1);
    btn_a = 0;
    wait_n(2);
    btn_a = 1;
    wait_n(2);
    chk("lvl_mid_release_bounce", lvl_a, 1);
    wait_n(8);
    chk("lvl_after_release_bounce", lvl_a, 1);
    chk("no_pulse_release_bounce", pulses_a, exp_a);
    btn_a = 0;
    wait_n(6);
    press_a();
    wait_n(12);
    chk("lvl_repress", lvl_a, 1);
    chk("pulse_repress", pulses_a, exp_a);
    btn_a = 0;
    wait_n(12);
    chk("lvl_released3", lvl_a, 0);
    repeat (3) begin
      press_a();
      wait_n(8);
      btn_a = 0;
      wait_n(12);
    end
    chk("three_presses", pulses_a, exp_a);
    press_a();
    wait_n(10);
    chk("lvl_before_rst", lvl_a, 1);
    rst_n = 0;
    #1;
    chk("rst_async_lvl_pressed", lvl_a, 0);
    chk("rst_async_p_pressed", p_a, 0);
    @(negedge clk);
    rst_n = 1;
    wait_n(5);
    rst_n = 0;
    #1;
    chk("rst_async_lvl_qual", lvl_a, 0);
    chk("rst_async_p_qual", p_a, 0);
    @(negedge clk);
    rst_n = 1;
    qa.push_back(cyc + 1 + N + D);
    exp_a++;
    wait_n(N + D);
    chk("lvl_before_post_rst", lvl_a, 0);
    wait_n(1);
    chk("lvl_post_rst", lvl_a, 1);
    wait_n(3);
    chk("pulse_post_rst", pulses_a, exp_a);
    btn_a = 0;
    wait_n(12);
    btn_b = 1;
    qb.push_back(cyc + 1 + N + DB);
    wait_n(100);
    chk("lvl_b_hold", lvl_b, 1);
    chk("single_pulse_b", pulses_b, 1);
    btn_b = 0;
    wait_n(6);
    chk("lvl_b_release", lvl_b, 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("total_pulses_a", pulses_a, exp_a);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
